// File: rtl/cis_dvp_capture.sv
// DVP camera capture front end: synchronizes the sensor pixel bus into the
// system clock domain, frames pixels with a small FSM, and hands them to the
// downstream consumer through a valid/ready FIFO with sof/sol tags.
//
// state   | meaning
// IDLE    | capture disabled, or waiting for vsync low after enable
// WAIT_VS | armed, waiting for the vsync rising edge of the next frame
// ACTIVE  | inside a frame, capturing pixels while hsync is high
module cis_dvp_capture #(
  parameter int DW         = 10,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 12
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic             cis_pclk_i,
  input  logic             cis_vsync_i,
  input  logic             cis_hsync_i,
  input  logic [DW-1:0]    cis_d_i,
  input  logic             enable_i,
  input  logic             clr_i,
  output logic [DW-1:0]    pix_data_o,
  output logic             pix_sof_o,
  output logic             pix_sol_o,
  output logic             pix_valid_o,
  input  logic             pix_ready_i,
  output logic             frame_done_o,
  output logic [CNT_W-1:0] line_width_o,
  output logic [CNT_W-1:0] line_cnt_o,
  output logic             overflow_o,
  output logic             busy_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = DW + 2;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [AW:0]      FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_VS = 2'd1, ACTIVE = 2'd2} state_t;

  state_t           state, state_nx;
  logic [2:0]       pclk_sync;
  logic [1:0]       vs_sync, hs_sync;
  logic [DW-1:0]    d_meta, d_sync;
  logic             pclk_ev, vs, hs;
  logic             hs_prev, sof_pend;
  logic             frame_end, capture, hs_fall;
  logic [CNT_W-1:0] pix_cnt, line_cnt, line_cnt_inc;
  logic [EW-1:0]    mem [FIFO_DEPTH];
  logic [EW-1:0]    head;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             full, push, pop, drop;

  assign pclk_ev = pclk_sync[1] & ~pclk_sync[2];
  assign vs      = vs_sync[1];
  assign hs      = hs_sync[1];

  // Two-flop synchronizers on all sensor inputs; pclk gets a third stage for edge detect.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      pclk_sync <= '0;
      vs_sync   <= '0;
      hs_sync   <= '0;
      d_meta    <= '0;
      d_sync    <= '0;
    end else begin
      pclk_sync <= {pclk_sync[1:0], cis_pclk_i};
      vs_sync   <= {vs_sync[0], cis_vsync_i};
      hs_sync   <= {hs_sync[0], cis_hsync_i};
      d_meta    <= cis_d_i;
      d_sync    <= d_meta;
    end
  end

  // FSM state register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state <= IDLE;
    else            state <= state_nx;
  end

  // FSM next state; dropping enable wins over every other transition.
  always_comb begin
    state_nx = state;
    if (!enable_i) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (!vs) state_nx = WAIT_VS;
        WAIT_VS: if (pclk_ev && vs) state_nx = ACTIVE;
        ACTIVE:  if (pclk_ev && !vs) state_nx = WAIT_VS;
        default: state_nx = IDLE;
      endcase
    end
  end

  // FSM outputs: per-event strobes used by the datapath.
  always_comb begin
    busy_o    = (state == ACTIVE);
    frame_end = (state == ACTIVE) && enable_i && pclk_ev && !vs;
    capture   = (state == ACTIVE) && pclk_ev && hs;
    hs_fall   = (state == ACTIVE) && pclk_ev && hs_prev && !hs;
  end

  // Previous sampled hsync (for sol / line end) and pending start-of-frame tag.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      hs_prev  <= 1'b0;
      sof_pend <= 1'b0;
    end else begin
      if (pclk_ev) hs_prev <= hs;
      if (state != ACTIVE) sof_pend <= 1'b1;
      else if (capture)    sof_pend <= 1'b0;
    end
  end

  // A line that ends on the same event as the frame still has to be counted.
  assign line_cnt_inc = (hs_fall && line_cnt != CNT_MAX) ? line_cnt + CNT_W'(1) : line_cnt;

  // Saturating pixel/line counters and their snapshot registers.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      pix_cnt      <= '0;
      line_cnt     <= '0;
      line_width_o <= '0;
      line_cnt_o   <= '0;
      frame_done_o <= 1'b0;
    end else begin
      frame_done_o <= frame_end;
      if (state != ACTIVE) begin
        pix_cnt  <= '0;
        line_cnt <= '0;
      end else begin
        if (hs_fall) begin
          line_width_o <= pix_cnt;
          pix_cnt      <= '0;
        end else if (capture && pix_cnt != CNT_MAX) begin
          pix_cnt <= pix_cnt + CNT_W'(1);
        end
        if (frame_end) begin
          line_cnt_o <= line_cnt_inc;
          line_cnt   <= '0;
        end else begin
          line_cnt <= line_cnt_inc;
        end
      end
    end
  end

  assign full        = (count == FULL_CNT);
  assign pix_valid_o = (count != '0);
  assign pop         = pix_valid_o & pix_ready_i;
  assign push        = capture & (~full | pop);
  assign drop        = capture & ~push;

  // FIFO storage: {sof, sol, data}.
  always_ff @(posedge wb_clk_i) begin
    if (push) mem[wr_ptr] <= {sof_pend, ~hs_prev, d_sync};
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + (AW+1)'(1);
      else if (pop && !push) count <= count - (AW+1)'(1);
    end
  end

  // Sticky overflow; a drop in the clearing cycle keeps it set.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni)  overflow_o <= 1'b0;
    else if (drop)   overflow_o <= 1'b1;
    else if (clr_i)  overflow_o <= 1'b0;
  end

  // Head is forced to zero when empty so stale entries never show.
  assign head = mem[rd_ptr];
  assign {pix_sof_o, pix_sol_o, pix_data_o} = pix_valid_o ? head : '0;

endmodule

// File: doc/cis_dvp_capture.md
CIS_DVP_CAPTURE -- requirements
Module: cis_dvp_capture

Interface
REQ-001 SHALL have parameter DW, default 10, giving the sensor pixel data width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, giving the output FIFO entries; the value is a power of two and at least 4.
REQ-003 SHALL have parameter CNT_W, default 12, giving the width of the pixel and line counters.
REQ-004 SHALL have ports:
- wb_clk_i  in  1  system clock; single clock domain.
- wb_rst_ni  in  1  asynchronous, active-low reset.
- cis_pclk_i  in  1  sensor pixel clock, asynchronous to wb_clk_i.
- cis_vsync_i  in  1  frame valid, active high, asynchronous.
- cis_hsync_i  in  1  line valid, active high, asynchronous.
- cis_d_i  in  DW  sensor pixel data, asynchronous.
- enable_i  in  1  capture enable.
- clr_i  in  1  synchronous clear of the sticky flags.
- pix_data_o  out  DW  FIFO head pixel.
- pix_sof_o  out  1  head pixel is the first pixel of a frame.
- pix_sol_o  out  1  head pixel is the first pixel of a line.
- pix_valid_o  out  1  FIFO head is valid.
- pix_ready_i  in  1  downstream ISP accepts the head pixel.
- frame_done_o  out  1  one-cycle pulse at end of frame.
- line_width_o  out  CNT_W  pixel count of the last completed line.
- line_cnt_o  out  CNT_W  line count of the last completed frame.
- overflow_o  out  1  sticky flag: a pixel was dropped.
- busy_o  out  1  FSM is in ACTIVE.

Function
REQ-005 SHALL pass cis_pclk_i, cis_vsync_i, cis_hsync_i and cis_d_i each through a 2-flop synchronizer, followed by one further stage on pclk for edge detection.
REQ-006 SHALL define a PCLK event as synchronized pclk high while the prior stage was low; hsync, vsync and data are sampled only on that cycle.
REQ-007 SHALL guarantee correct operation for f(cis_pclk_i) <= f(wb_clk_i)/4; behaviour above that rate is undefined.
REQ-008 SHALL implement an FSM with states IDLE, WAIT_VS and ACTIVE.
- IDLE: if enable_i=1 and sampled vsync=0, go to WAIT_VS.
- WAIT_VS: on a PCLK event with vsync=1, go to ACTIVE.
- ACTIVE: on a PCLK event with vsync=0, pulse frame_done_o and go to WAIT_VS.
REQ-009 SHALL move to IDLE from any state on the cycle after enable_i=0; an in-progress frame is abandoned, no frame_done_o is produced, and the FIFO keeps draining.
REQ-010 SHALL, while in IDLE or WAIT_VS, never capture pixels, so a partial frame is never captured when enable_i is asserted mid-frame.
REQ-011 SHALL, in ACTIVE, capture a pixel on each PCLK event with sampled hsync=1.
- Each entry pushes {sof, sol, data}.
- sol=1 on the first pixel after hsync rises.
- sof=1 on the first pixel of the frame.
REQ-012 SHALL push a capture when the FIFO is not full, or when it is full and a pop occurs in the same cycle; otherwise the pixel is dropped and overflow_o is set.
REQ-013 SHALL pop on pix_valid_o && pix_ready_i; pix_valid_o=1 whenever the FIFO count is nonzero; pix_data_o, pix_sof_o and pix_sol_o are stable while pix_valid_o=1 && pix_ready_i=0.
REQ-014 SHALL give a minimum latency of 1 wb_clk_i cycle from the push cycle to pix_valid_o=1 when the FIFO is empty.
REQ-015 SHALL count pixels per line (the count includes dropped pixels) and on hsync falling in ACTIVE load line_width_o with the count, then reset the count to 0.
REQ-016 SHALL count lines per frame (hsync falling edges) and on the frame_done_o cycle load line_cnt_o with the count, then reset the count to 0.
REQ-017 SHALL saturate both counters at 2^CNT_W-1.
REQ-018 SHALL, when clr_i=1, clear overflow_o; if clr_i coincides with a drop, overflow_o=1.
REQ-019 SHALL set busy_o=1 exactly when the FSM is in ACTIVE.

Reset
REQ-020 SHALL, while wb_rst_ni=0, asynchronously force:
- FSM to IDLE.
- FIFO empty.
- All synchronizer flops to 0.
- pix_valid_o, pix_sof_o, pix_sol_o, frame_done_o, overflow_o and busy_o to 0.
- pix_data_o, line_width_o, line_cnt_o and both counters to 0.
REQ-021 SHALL leave reset release synchronous to wb_clk_i (reset-synchronizer responsibility of the parent); the first PCLK event is recognized no earlier than 3 cycles after release.
REQ-022 SHALL, on reset during ACTIVE, discard all FIFO contents and partial counts, with no frame_done_o.

Verification
REQ-023 SHALL cover: wb_clk=4xpclk, enable=1, frame of 3 lines x 16 pixels, ready=1 -> 48 pixels in order; sof on pixel 0 only; sol on pixels 0, 16, 32; line_width_o=16; line_cnt_o=3; one frame_done_o pulse.
REQ-024 SHALL cover: ready=0 for a 12-pixel line, FIFO_DEPTH=8 -> first 8 pixels retained; overflow_o=1; line_width_o=12; after ready=1 exactly 8 pixels are delivered; clr_i -> overflow_o=0.
REQ-025 SHALL cover: enable_i raised mid-frame (vsync=1) -> no pixels until the next vsync rising edge; the first delivered pixel has sof=1.
REQ-026 SHALL cover: FIFO full with a pop and a capture in the same cycle -> no drop; overflow_o stays 0; count stays 8.
REQ-027 SHALL cover: wb_rst_ni=0 asserted mid-line with 5 pixels buffered -> pix_valid_o=0 immediately; all outputs 0; after release and a new frame, capture is correct.
REQ-028 SHALL cover: a line of 5000 pixels with CNT_W=12 -> line_width_o=4095 (saturated).
